// File: rtl/pll_sup_pkg.sv
// Shared types, default parameters and counter sizing for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    localparam int DEF_RESET_PULSE_CYCLES  = 10;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_RETRY_MAX           = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width of an unsigned counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit; both flops reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock and gates system reset from the reference clock.
// Optional lock-loss counter enabled by defining PLL_SUP_LOSS_CNT_EN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RESET_PULSE_CYCLES  = DEF_RESET_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int RETRY_MAX           = DEF_RETRY_MAX
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_in,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       lock_ok,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);
    localparam int TW = cnt_width(max3(RESET_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                       LOCK_STABLE_CYCLES));
    localparam logic [TW-1:0] PULSE_LAST   = TW'(RESET_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(RETRY_MAX);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      retry_q, retry_d;
    logic [3:0]      retry_inc;
    logic            locked_s;
    logic            pll_rst_q, sys_rst_q, lock_ok_q, fail_q;

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked_in),
        .q_o   (locked_s)
    );

    assign retry_inc = retry_q + 4'd1;

    // Timer holds at all-ones rather than wrapping.
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
        retry_d = retry_q;
        if (force_relock) begin
            state_d = ST_RESET;
            timer_d = '0;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (timer_q == PULSE_LAST) begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end
                end
                ST_WAIT: begin
                    // Lock arriving on the timeout cycle wins over the retry.
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d = '0;
                        retry_d = retry_inc;
                        state_d = (retry_inc >= RETRY_LIMIT) ? ST_FAIL : ST_RESET;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                    end
                end
                ST_RUN: begin
                    timer_d = '0;
                    if (!locked_s) state_d = ST_RESET;
                end
                ST_FAIL: timer_d = '0;
                default: begin
                    state_d = ST_RESET;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RESET;
            timer_q   <= '0;
            retry_q   <= 4'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            sys_rst_q <= (state_d != ST_RUN);
            lock_ok_q <= (state_d == ST_RUN);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign lock_ok   = lock_ok_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

`ifdef PLL_SUP_LOSS_CNT_EN
    logic [7:0] loss_q, loss_d;

    // A relock request in the same cycle as a drop is not a loss.
    always_comb begin
        loss_d = loss_q;
        if ((state_q == ST_RUN) && !locked_s && !force_relock && (loss_q != 8'hFF))
            loss_d = loss_q + 8'd1;
    end

    always_ff @(posedge refclk) begin
        if (rst) loss_q <= 8'd0;
        else     loss_q <= loss_d;
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;
    localparam int RP = 4;
    localparam int TO = 20;
    localparam int SC = 8;
    localparam int RM = 2;

`ifdef PLL_SUP_LOSS_CNT_EN
    localparam logic [7:0] EXP_LOSS1   = 8'd1;
    localparam logic [7:0] EXP_LOSSSAT = 8'd255;
`else
    localparam logic [7:0] EXP_LOSS1   = 8'd0;
    localparam logic [7:0] EXP_LOSSSAT = 8'd0;
`endif

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked_in = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst, sys_rst, lock_ok, fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int errors = 0;
    int checks = 0;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .RESET_PULSE_CYCLES (RP),
        .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES (SC),
        .RETRY_MAX          (RM)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked_in   (locked_in),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .lock_ok     (lock_ok),
        .fail        (fail),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    // Reference model: phase plus cycles spent in it, and a two-deep lock history.
    localparam int PH_RESET = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;
    int   m_phase = PH_RESET;
    int   m_elapsed = 0;
    int   m_retry = 0;
    int   m_loss = 0;
    logic m_h1 = 1'b0, m_h2 = 1'b0;

    function automatic void model_step(input logic r, input logic lk, input logic fr);
        logic seen;
        if (r) begin
            m_phase = PH_RESET; m_elapsed = 0; m_retry = 0; m_loss = 0;
            m_h1 = 1'b0; m_h2 = 1'b0;
            return;
        end
        seen = m_h2;
        m_h2 = m_h1;
        m_h1 = lk;
        if (fr) begin
            m_phase = PH_RESET; m_elapsed = 0; m_retry = 0;
            return;
        end
        case (m_phase)
            PH_RESET: begin
                m_elapsed++;
                if (m_elapsed == RP) begin m_phase = PH_WAIT; m_elapsed = 0; end
            end
            PH_WAIT: begin
                if (seen) begin
                    m_phase = PH_STABLE; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == TO) begin
                        m_retry++;
                        m_elapsed = 0;
                        m_phase = (m_retry >= RM) ? PH_FAIL : PH_RESET;
                    end
                end
            end
            PH_STABLE: begin
                if (!seen) begin
                    m_phase = PH_WAIT; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == SC) begin m_phase = PH_RUN; m_elapsed = 0; end
                end
            end
            PH_RUN: begin
                if (!seen) begin
`ifdef PLL_SUP_LOSS_CNT_EN
                    if (m_loss < 255) m_loss++;
`endif
                    m_phase = PH_RESET; m_elapsed = 0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] mdl_vec();
        return {logic'(m_phase == PH_RESET || m_phase == PH_FAIL), logic'(m_phase != PH_RUN),
                logic'(m_phase == PH_RUN), logic'(m_phase == PH_FAIL), 4'(m_retry), 8'(m_loss)};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {pll_rst, sys_rst, lock_ok, fail, retry_cnt, loss_cnt};
    endfunction

    task automatic drive(input logic r, input logic lk, input logic fr);
        rst = r; locked_in = lk; force_relock = fr;
        @(posedge refclk);
        model_step(r, lk, fr);
        @(negedge refclk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== 16'hC000) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", dut_vec(), 16'hC000);
        end
    endtask

    task automatic test_normal_lock();
        drive(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 32; c++) begin
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL normal_lock c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
            end
            if (c < 8) begin
                checks++;
                if (pll_rst !== logic'(c < 4)) begin
                    errors++;
                    $display("FAIL normal_pll_rst c=%0d got=%b want=%b", c, pll_rst, c < 4);
                end
            end
            if (c == 20 || c == 21) begin
                checks++;
                if ({sys_rst, lock_ok} !== ((c == 21) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL normal_release c=%0d got=%b%b", c, sys_rst, lock_ok);
                end
            end
            drive(1'b0, logic'(c >= 10), 1'b0);
        end
    endtask

    task automatic test_glitch();
        drive(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 36; c++) begin
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL glitch c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
            end
            if (c == 27 || c == 28) begin
                checks++;
                if (lock_ok !== logic'(c == 28) || retry_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL glitch_release c=%0d got lock_ok=%b retry=%0d", c, lock_ok, retry_cnt);
                end
            end
            drive(1'b0, logic'(c >= 10 && c != 16), 1'b0);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL simult c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
            end
            if (c == 28) begin
                checks++;
                if ({pll_rst, sys_rst, lock_ok} !== 3'b110 || loss_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL simult_relock got=%b%b%b loss=%0d want=110 loss=0",
                             pll_rst, sys_rst, lock_ok, loss_cnt);
                end
            end
            drive(1'b0, logic'(c >= 10 && c < 25), logic'(c == 27));
        end
    endtask

    task automatic test_timeout_fail();
        int highs = 0;
        drive(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 70; c++) begin
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL timeout c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
            end
            if (c < 48 && pll_rst === 1'b1) highs++;
            if (c == 24) begin
                checks++;
                if (retry_cnt !== 4'd1) begin
                    errors++; $display("FAIL retry_first got=%0d want=1", retry_cnt);
                end
            end
            if (c == 48) begin
                checks++;
                if (highs != 8) begin
                    errors++; $display("FAIL pulse_cycles got=%0d want=8", highs);
                end
            end
            if (c == 50) begin
                checks++;
                if ({pll_rst, sys_rst, lock_ok, fail} !== 4'b1101 || retry_cnt !== 4'd2) begin
                    errors++;
                    $display("FAIL fail_state got=%b%b%b%b retry=%0d want=1101 retry=2",
                             pll_rst, sys_rst, lock_ok, fail, retry_cnt);
                end
            end
            if (c == 56 || c == 60) begin
                checks++;
                if (pll_rst !== logic'(c == 56) || fail !== 1'b0 || retry_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL relock_pulse c=%0d got pll_rst=%b fail=%b retry=%0d",
                             c, pll_rst, fail, retry_cnt);
                end
            end
            drive(1'b0, 1'b0, logic'(c == 55));
        end
    endtask

    task automatic test_loss_run();
        drive(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 36; c++) begin
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL loss c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
            end
            if (c == 32 || c == 33) begin
                checks++;
                if (sys_rst !== logic'(c == 33) || pll_rst !== logic'(c == 33) ||
                    (c == 33 && loss_cnt !== EXP_LOSS1)) begin
                    errors++;
                    $display("FAIL loss_first c=%0d got sys_rst=%b pll_rst=%b loss=%0d",
                             c, sys_rst, pll_rst, loss_cnt);
                end
            end
            drive(1'b0, logic'(c >= 10 && c < 30), 1'b0);
        end
        for (int k = 0; k < 260; k++) begin
            for (int j = 0; j < 28; j++) begin
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++;
                    $display("FAIL loss_loop k=%0d j=%0d got=%h want=%h", k, j, dut_vec(), mdl_vec());
                end
                if (j == 23) begin
                    checks++;
                    if (lock_ok !== 1'b1) begin
                        errors++; $display("FAIL loss_loop_run k=%0d got lock_ok=%b", k, lock_ok);
                    end
                end
                drive(1'b0, logic'(j < 24), 1'b0);
            end
        end
        checks++;
        if (loss_cnt !== EXP_LOSSSAT) begin
            errors++; $display("FAIL loss_saturate got=%0d want=%0d", loss_cnt, EXP_LOSSSAT);
        end
    endtask

    task automatic test_random();
        int   hold = 0;
        logic lk = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 4000; c++) begin
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
            end
            if (hold == 0) begin
                lk   = logic'($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 40);
            end
            hold--;
            drive(logic'($urandom_range(0, 999) == 0), lk, logic'($urandom_range(0, 199) == 0));
        end
    endtask

    initial begin
        @(negedge refclk);
        test_reset();
        test_normal_lock();
        test_glitch();
        test_simultaneous();
        test_timeout_fail();
        test_loss_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
